// File: rtl/pic_pkg.sv
// pic_pkg: definitions shared by the 8259 PIC blocks.
//   - OCW2 command encodings, as {R, SL, EOI}
//   - acknowledge FSM state type
//   - rotate_right / rotate_left helpers, also used by the priority resolver
package pic_pkg;

    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS       = 3'b101;
    localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
    localparam logic [2:0] OCW2_ROT_SP       = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK1  = 2'd1,
        ST_WAIT2 = 2'd2,
        ST_ACK2  = 2'd3
    } ack_state_t;

    // r[i] = v[(i + n) mod 8]: bit n of v ends up at position 0.
    function automatic logic [7:0] rotate_right(input logic [7:0] v, input logic [2:0] n);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[3'(i) + n];
        return r;
    endfunction

    // Inverse of rotate_right: bit 0 of v ends up at position n.
    function automatic logic [7:0] rotate_left(input logic [7:0] v, input logic [2:0] n);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[3'(i) + n] = v[i];
        return r;
    endfunction

endpackage

// File: rtl/in_service_control_isr_highest_finder.sv
// isr_highest_finder: combinational search for the highest-priority set ISR bit.
// Level (priority_rotate + 1) mod 8 is the highest priority. The search wraps
// from 7 back to 0.
// Ports:
//   isr             in  8  in-service register
//   priority_rotate in  3  level of the lowest-priority IR
//   highest         out 8  one-hot of the winning bit (0 when isr == 0)
//   level           out 3  level number of the winning bit
//   valid           out 1  isr has at least one bit set
module isr_highest_finder
    import pic_pkg::*;
(
    input  logic [7:0] isr,
    input  logic [2:0] priority_rotate,
    output logic [7:0] highest,
    output logic [2:0] level,
    output logic       valid
);

    logic [2:0] start;
    logic [7:0] rot;
    logic       found;

    // Rotate so the highest-priority level sits at bit 0. The first set bit
    // in rot is then the winner.
    assign start = priority_rotate + 3'd1;
    assign rot   = rotate_right(isr, start);
    assign valid = |isr;

    always_comb begin
        found = 1'b0;
        level = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                level = start + 3'(i);
            end
        end
        highest = found ? (8'd1 << level) : 8'd0;
    end

endmodule

// File: rtl/in_service_control.sv
// in_service_control: 8259 ISR owner and INTA acknowledge sequencer.
// Takes the one-hot winner from the priority resolver and runs the two-pulse
// INTA cycle. It maintains the ISR, decodes the OCW2 EOI and rotate commands,
// and returns the vector byte {vector_base, level}.
// Build option: define INTA_SYNC_EN to place a 2-flop synchronizer on inta_n
// ahead of edge detection. This adds 2 cycles to every INTA-related latency.
// Ports:
//   clock, reset              rising-edge clock, async active-high reset
//   interrupt[7:0]            one-hot winning request (0 = none)
//   inta_n                    CPU acknowledge, active low
//   ocw2_write/cmd/level      OCW2 strobe, {R,SL,EOI}, L2..L0
//   auto_eoi_config           ICW4 AEOI
//   vector_base[4:0]          ICW2 T7..T3
//   int_out                   INT to CPU
//   in_service_register[7:0]  ISR, to resolver
//   priority_rotate[2:0]      lowest-priority level, to resolver
//   clear_interrupt_request   one-cycle pulse clearing the acknowledged IRR bit
//   data_out, data_out_enable vector byte and its bus enable
module in_service_control
    import pic_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] interrupt,
    input  logic       inta_n,
    input  logic       ocw2_write,
    input  logic [2:0] ocw2_cmd,
    input  logic [2:0] ocw2_level,
    input  logic       auto_eoi_config,
    input  logic [4:0] vector_base,
    output logic       int_out,
    output logic [7:0] in_service_register,
    output logic [2:0] priority_rotate,
    output logic [7:0] clear_interrupt_request,
    output logic [7:0] data_out,
    output logic       data_out_enable
);

    ack_state_t state, state_next;
    logic [7:0] isr;
    logic [2:0] pri_rot;
    logic       auto_rotate;
    logic [7:0] ack_vec;
    logic [2:0] ack_level;

    // ---------------- INTA edge detection ----------------
    logic inta_s, inta_q, inta_fall, inta_rise;

`ifdef INTA_SYNC_EN
    logic [1:0] inta_sync;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) inta_sync <= 2'b11;
        else       inta_sync <= {inta_sync[0], inta_n};
    end
    assign inta_s = inta_sync[1];
`else
    assign inta_s = inta_n;
`endif

    // Reset to the idle (high) level so that a release from reset does not
    // look like an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) inta_q <= 1'b1;
        else       inta_q <= inta_s;
    end

    assign inta_fall = inta_q & ~inta_s;
    assign inta_rise = ~inta_q & inta_s;

    // ---------------- highest-priority ISR bit ----------------
    logic [7:0] hi_onehot;
    logic [2:0] hi_level;
    logic       hi_valid;

    isr_highest_finder u_finder (
        .isr             (isr),
        .priority_rotate (pri_rot),
        .highest         (hi_onehot),
        .level           (hi_level),
        .valid           (hi_valid)
    );

    // Level of the acknowledged request. An all-zero (spurious) request
    // reports IR7.
    logic [2:0] int_level;
    always_comb begin
        int_level = 3'd7;
        for (int i = 7; i >= 0; i--)
            if (interrupt[i]) int_level = 3'(i);
    end

    // ---------------- acknowledge FSM ----------------
    logic [7:0] inta_set;   // ISR bits set by the first INTA pulse
    logic [7:0] aeoi_clr;   // ISR bit cleared by automatic EOI
    logic       aeoi_rot;

    always_comb begin
        state_next = state;
        inta_set   = 8'd0;
        aeoi_clr   = 8'd0;
        aeoi_rot   = 1'b0;
        case (state)
            ST_IDLE:  if (inta_fall) begin
                          state_next = ST_ACK1;
                          inta_set   = interrupt;
                      end
            ST_ACK1:  if (inta_rise) state_next = ST_WAIT2;
            ST_WAIT2: if (inta_fall) state_next = ST_ACK2;
            ST_ACK2:  if (inta_rise) begin
                          state_next = ST_IDLE;
                          if (auto_eoi_config && ack_vec != 8'd0) begin
                              aeoi_clr = ack_vec;
                              aeoi_rot = auto_rotate;
                          end
                      end
            default:  state_next = ST_IDLE;
        endcase
    end

    // ---------------- OCW2 decode ----------------
    logic [7:0] ocw_clr;
    logic       ocw_rot_en;
    logic [2:0] ocw_rot_val;
    logic       auto_rotate_next;

    always_comb begin
        ocw_clr          = 8'd0;
        ocw_rot_en       = 1'b0;
        ocw_rot_val      = ocw2_level;
        auto_rotate_next = auto_rotate;
        if (ocw2_write) begin
            case (ocw2_cmd)
                OCW2_NS_EOI:       ocw_clr = hi_onehot;
                OCW2_SP_EOI:       ocw_clr = 8'd1 << ocw2_level;
                OCW2_ROT_NS:       if (hi_valid) begin
                                       ocw_clr     = hi_onehot;
                                       ocw_rot_en  = 1'b1;
                                       ocw_rot_val = hi_level;
                                   end
                OCW2_ROT_SP:       begin
                                       ocw_clr    = 8'd1 << ocw2_level;
                                       ocw_rot_en = 1'b1;
                                   end
                OCW2_SET_PRI:      ocw_rot_en = 1'b1;
                OCW2_ROT_AEOI_SET: auto_rotate_next = 1'b1;
                OCW2_ROT_AEOI_CLR: auto_rotate_next = 1'b0;
                default:           ;
            endcase
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                   <= ST_IDLE;
            isr                     <= 8'd0;
            pri_rot                 <= 3'd7;
            auto_rotate             <= 1'b0;
            ack_vec                 <= 8'd0;
            ack_level               <= 3'd0;
            clear_interrupt_request <= 8'd0;
            data_out                <= 8'd0;
            data_out_enable         <= 1'b0;
        end else begin
            state       <= state_next;
            auto_rotate <= auto_rotate_next;
            // A bit set by INTA on the same edge as a clear keeps its set.
            isr <= (isr & ~(ocw_clr | aeoi_clr)) | inta_set;
            // An OCW2 priority write takes precedence over an AEOI rotation.
            if (ocw_rot_en)    pri_rot <= ocw_rot_val;
            else if (aeoi_rot) pri_rot <= ack_level;

            clear_interrupt_request <= inta_set;
            if (state == ST_IDLE && inta_fall) begin
                ack_vec   <= interrupt;
                ack_level <= int_level;
            end
            if (state == ST_WAIT2 && inta_fall) begin
                data_out        <= {vector_base, ack_level};
                data_out_enable <= 1'b1;
            end
            if (state == ST_ACK2 && inta_rise) begin
                data_out        <= 8'd0;
                data_out_enable <= 1'b0;
            end
        end
    end

    // INT stays asserted from the first acknowledge until the end of the
    // second pulse.
    assign int_out             = (state == ST_IDLE) ? |interrupt : 1'b1;
    assign in_service_register = isr;
    assign priority_rotate     = pri_rot;

endmodule

// File: tb/tb_in_service_control.sv
module tb_in_service_control;

`ifdef INTA_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] interrupt = 8'd0;
    logic       inta_n = 1'b1;
    logic       ocw2_write = 1'b0;
    logic [2:0] ocw2_cmd = 3'd0;
    logic [2:0] ocw2_level = 3'd0;
    logic       auto_eoi_config = 1'b0;
    logic [4:0] vector_base = 5'b00100;
    logic       int_out;
    logic [7:0] in_service_register;
    logic [2:0] priority_rotate;
    logic [7:0] clear_interrupt_request;
    logic [7:0] data_out;
    logic       data_out_enable;

    int errors = 0;
    int checks = 0;
    logic [7:0] got_vec;

    in_service_control dut (
        .clock                   (clock),
        .reset                   (reset),
        .interrupt               (interrupt),
        .inta_n                  (inta_n),
        .ocw2_write              (ocw2_write),
        .ocw2_cmd                (ocw2_cmd),
        .ocw2_level              (ocw2_level),
        .auto_eoi_config         (auto_eoi_config),
        .vector_base             (vector_base),
        .int_out                 (int_out),
        .in_service_register     (in_service_register),
        .priority_rotate         (priority_rotate),
        .clear_interrupt_request (clear_interrupt_request),
        .data_out                (data_out),
        .data_out_enable         (data_out_enable)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 first pulse low, 2 between pulses, 3 second pulse low
    int         m_phase;
    logic [7:0] m_isr, m_ackv, m_clr, m_do;
    logic [2:0] m_pr, m_lvl;
    logic       m_arot, m_doe;
    logic [3:0] m_hist;   // m_hist[k] = inta_n sampled k edges ago

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_phase <= 0; m_isr <= 8'd0; m_ackv <= 8'd0; m_clr <= 8'd0;
            m_do <= 8'd0; m_pr <= 3'd7; m_lvl <= 3'd0; m_arot <= 1'b0;
            m_doe <= 1'b0; m_hist <= 4'hF;
        end else begin
            automatic logic [3:0] h = {m_hist[2:0], inta_n};
            automatic logic fall = h[LAT] && !h[LAT-1];
            automatic logic rise = !h[LAT] && h[LAT-1];
            automatic logic [7:0] setm = 8'd0, clrm = 8'd0;
            automatic int pr_new = m_pr;
            automatic int ph = m_phase;
            automatic int hi = -1;
            automatic logic [7:0] o_do = m_do;
            automatic logic o_doe = m_doe;
            automatic logic [7:0] ackv = m_ackv;
            automatic logic [2:0] lvl = m_lvl;
            automatic logic arot = m_arot;
            automatic logic ocw_pr = 1'b0;
            m_hist <= h;
            case (ph)
                0: if (fall) begin
                       ackv = interrupt; lvl = 3'd7;
                       for (int i = 7; i >= 0; i--) if (interrupt[i]) lvl = 3'(i);
                       setm = interrupt; ph = 1;
                   end
                1: if (rise) ph = 2;
                2: if (fall) begin o_do = {vector_base, m_lvl}; o_doe = 1'b1; ph = 3; end
                default: if (rise) begin
                       o_do = 8'd0; o_doe = 1'b0; ph = 0;
                       if (auto_eoi_config && m_ackv != 0) begin
                           clrm = m_ackv;
                           if (m_arot) pr_new = m_lvl;
                       end
                   end
            endcase
            // highest-priority set ISR level: walk from (pr+1) upward, wrapping
            for (int k = 8; k >= 1; k--)
                if (m_isr[(m_pr + k) % 8]) hi = (m_pr + k) % 8;
            if (ocw2_write) begin
                case (ocw2_cmd)
                    3'b001: if (hi >= 0) clrm[hi] = 1'b1;
                    3'b011: clrm[ocw2_level] = 1'b1;
                    3'b101: if (hi >= 0) begin clrm[hi] = 1'b1; pr_new = hi; ocw_pr = 1; end
                    3'b111: begin clrm[ocw2_level] = 1'b1; pr_new = ocw2_level; ocw_pr = 1; end
                    3'b110: begin pr_new = ocw2_level; ocw_pr = 1; end
                    3'b100: arot = 1'b1;
                    3'b000: arot = 1'b0;
                    default: ;
                endcase
            end
            m_isr <= (m_isr & ~clrm) | setm;
            m_pr <= 3'(pr_new);
            m_clr <= setm;
            m_phase <= ph; m_do <= o_do; m_doe <= o_doe;
            m_ackv <= ackv; m_lvl <= lvl; m_arot <= arot;
        end
    end

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // every-cycle comparison against the model
    always @(negedge clock) begin
        if (!reset) begin
            cmp("model.int_out", {7'd0, int_out}, {7'd0, (m_phase != 0) || (|interrupt)});
            cmp("model.isr", in_service_register, m_isr);
            cmp("model.rot", {5'd0, priority_rotate}, {5'd0, m_pr});
            cmp("model.clr", clear_interrupt_request, m_clr);
            cmp("model.doe", {7'd0, data_out_enable}, {7'd0, m_doe});
            cmp("model.dout", data_out, m_do);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic ocw2(input logic [2:0] c, input logic [2:0] l);
        ocw2_write = 1'b1; ocw2_cmd = c; ocw2_level = l;
        tick(1);
        ocw2_write = 1'b0;
    endtask

    task automatic inta_seq(input logic [7:0] irq);
        interrupt = irq;
        tick(1);
        inta_n = 1'b0; tick(LAT);
        interrupt = 8'd0;
        inta_n = 1'b1; tick(LAT);
        inta_n = 1'b0; tick(LAT);
        got_vec = data_out;
        inta_n = 1'b1; tick(LAT);
    endtask

    initial begin
        tick(3);
        reset = 1'b0;
        tick(1);
        cmp("reset.isr", in_service_register, 8'h00);
        cmp("reset.rot", {5'd0, priority_rotate}, 8'd7);
        cmp("reset.int_out", {7'd0, int_out}, 8'd0);

        // basic acknowledge of IR2
        interrupt = 8'h04; tick(1);
        cmp("t1.int_out", {7'd0, int_out}, 8'd1);
        inta_n = 1'b0; tick(LAT);
        cmp("t1.isr", in_service_register, 8'h04);
        cmp("t1.clr", clear_interrupt_request, 8'h04);
        interrupt = 8'h00;
        inta_n = 1'b1; tick(LAT);
        cmp("t1.int_held", {7'd0, int_out}, 8'd1);
        inta_n = 1'b0; tick(LAT);
        cmp("t1.doe", {7'd0, data_out_enable}, 8'd1);
        cmp("t1.vector", data_out, 8'h22);
        inta_n = 1'b1; tick(LAT);
        cmp("t1.int_end", {7'd0, int_out}, 8'd0);
        cmp("t1.doe_end", {7'd0, data_out_enable}, 8'd0);
        ocw2(3'b011, 3'd2);
        cmp("t1.sp_eoi", in_service_register, 8'h00);

        // non-specific EOI walks down the ISR
        inta_seq(8'h02); inta_seq(8'h08);
        cmp("t2.isr", in_service_register, 8'h0A);
        ocw2(3'b001, 3'd0); cmp("t2.ns1", in_service_register, 8'h08);
        ocw2(3'b001, 3'd0); cmp("t2.ns2", in_service_register, 8'h00);
        ocw2(3'b001, 3'd0); cmp("t2.ns3", in_service_register, 8'h00);
        cmp("t2.rot", {5'd0, priority_rotate}, 8'd7);

        // rotate on non-specific EOI with IR1 highest
        inta_seq(8'h01); inta_seq(8'h80);
        ocw2(3'b110, 3'd0);
        cmp("t3.setpri", {5'd0, priority_rotate}, 8'd0);
        ocw2(3'b101, 3'd0);
        cmp("t3.isr", in_service_register, 8'h01);
        cmp("t3.rot", {5'd0, priority_rotate}, 8'd7);
        ocw2(3'b011, 3'd0);

        // automatic EOI with automatic rotation
        auto_eoi_config = 1'b1;
        ocw2(3'b100, 3'd0);
        inta_seq(8'h20);
        cmp("t4.vector", got_vec, 8'h25);
        cmp("t4.isr", in_service_register, 8'h00);
        cmp("t4.rot", {5'd0, priority_rotate}, 8'd5);
        auto_eoi_config = 1'b0;
        ocw2(3'b000, 3'd0);
        ocw2(3'b110, 3'd7);

        // spurious acknowledge
        inta_seq(8'h00);
        cmp("t5.vector", got_vec, 8'h27);
        cmp("t5.isr", in_service_register, 8'h00);

        // same-bit set and clear on one edge: set wins
        inta_seq(8'h04);
        interrupt = 8'h04;
        tick(1);
        inta_n = 1'b0;
        repeat (LAT - 1) tick(1);
        ocw2(3'b011, 3'd2);
        interrupt = 8'h00;
        cmp("t6.set_wins", in_service_register, 8'h04);
        inta_n = 1'b1; tick(LAT);
        inta_n = 1'b0; tick(LAT);
        inta_n = 1'b1; tick(LAT);
        ocw2(3'b111, 3'd2);
        cmp("t6.rot_sp", in_service_register, 8'h00);
        ocw2(3'b111, 3'd5);
        cmp("t6.rot_clear_bit", {5'd0, priority_rotate}, 8'd5);
        ocw2(3'b010, 3'd1);
        cmp("t6.nop", {5'd0, priority_rotate}, 8'd5);
        ocw2(3'b110, 3'd7);

        // asynchronous reset while waiting for the second pulse
        inta_seq(8'h40);
        interrupt = 8'h01; tick(1);
        inta_n = 1'b0; tick(LAT);
        interrupt = 8'h00;
        inta_n = 1'b1; tick(LAT);
        cmp("t7.int_wait2", {7'd0, int_out}, 8'd1);
        reset = 1'b1; #1;
        cmp("t7.int_out", {7'd0, int_out}, 8'd0);
        cmp("t7.isr", in_service_register, 8'h00);
        cmp("t7.rot", {5'd0, priority_rotate}, 8'd7);
        cmp("t7.doe", {7'd0, data_out_enable}, 8'd0);
        tick(1); reset = 1'b0; tick(2);

        // asynchronous reset while the vector is on the bus
        interrupt = 8'h08; tick(1);
        inta_n = 1'b0; tick(LAT);
        interrupt = 8'h00;
        inta_n = 1'b1; tick(LAT);
        inta_n = 1'b0; tick(LAT);
        cmp("t8.doe_on", {7'd0, data_out_enable}, 8'd1);
        reset = 1'b1; #1;
        cmp("t8.doe_off", {7'd0, data_out_enable}, 8'd0);
        cmp("t8.dout", data_out, 8'h00);
        inta_n = 1'b1;
        tick(2); reset = 1'b0; tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/in_service_control.md
Name: in_service_control

Overview:
- Downstream stage of the priority resolver in the 8259 PIC.
- Consumes the one-hot `interrupt` vector and runs the two-pulse INTA acknowledge sequence.
- Owns the In-Service Register (ISR), handles OCW2 EOI and rotation commands, and drives the interrupt vector byte.
- Feeds `in_service_register` and `priority_rotate` back to the resolver, and `clear_interrupt_request` to the IRR.

Parameters:
None.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
interrupt  input  8  one-hot winning request from priority resolver (all-zero = none)
inta_n  input  1  CPU interrupt acknowledge, active-low level
ocw2_write  input  1  one-cycle strobe: OCW2 command valid
ocw2_cmd  input  3  OCW2 bits {R,SL,EOI}
ocw2_level  input  3  OCW2 L2..L0
auto_eoi_config  input  1  ICW4 AEOI mode
vector_base  input  5  ICW2 T7..T3
int_out  output  1  interrupt request to CPU
in_service_register  output  8  ISR, to resolver
priority_rotate  output  3  level number of lowest-priority IR, to resolver
clear_interrupt_request  output  8  one-cycle pulse; clears the acknowledged IRR bit
data_out  output  8  vector byte
data_out_enable  output  1  high while data_out drives the bus

Behaviour:
- Reset values:
  - isr = 0; priority_rotate = 3'd7 (IR0 highest); auto_rotate = 0.
  - state = IDLE; all outputs 0.
- INTA edge detection: inta_n is registered once (inta_q).
  - Falling edge = inta_q & ~inta_n.
  - Rising edge = ~inta_q & inta_n.
  - Edge actions occur at the clock edge that detects them (1-cycle latency from pin).
- States:
  - IDLE
    - int_out = |interrupt (combinational from the registered state, plus the input).
    - On falling edge:
      - Latch ack_vec = interrupt.
      - If ack_vec != 0: isr |= ack_vec; clear_interrupt_request = ack_vec for 1 cycle.
      - If ack_vec == 0 (spurious): ack_level = 7, ISR not set, no clear pulse.
      - Go to ACK1.
  - ACK1
    - int_out held 1.
    - Rising edge of first pulse -> WAIT2.
  - WAIT2
    - int_out held 1.
    - On falling edge: data_out = {vector_base, ack_level}; data_out_enable = 1; go to ACK2.
  - ACK2
    - data_out_enable stays 1 until the rising edge.
    - At the rising edge: data_out_enable = 0 and int_out = 0.
    - If auto_eoi_config and ack_vec != 0: clear that ISR bit; if auto_rotate, priority_rotate = ack_level.
    - Go to IDLE.
- OCW2 handling, on ocw2_write, decoded from {R,SL,EOI}:
  - 001 non-specific EOI: clear the highest-priority set ISR bit (priority order follows priority_rotate).
  - 011 specific EOI: clear isr[ocw2_level].
  - 101 rotate on non-specific EOI: clear the highest-priority bit; priority_rotate = its level.
  - 111 rotate on specific EOI: clear isr[ocw2_level]; priority_rotate = ocw2_level.
  - 100: auto_rotate = 1.
  - 000: auto_rotate = 0.
  - 110 set priority: priority_rotate = ocw2_level; ISR unchanged.
  - 010: no operation.
- Boundary rules:
  - Non-specific EOI with isr == 0: no change; no rotation.
  - Specific EOI on an already-clear bit: no change; rotation still applied for 111.
  - Same-cycle ISR set (INTA) and ISR clear (EOI/AEOI):
    - Different bits: both take effect.
    - Same bit: set wins.
  - Same-cycle priority_rotate writes from OCW2 and AEOI-rotate: OCW2 wins.
  - inta_n rising in IDLE, or falling in ACK1/ACK2: ignored.
  - ocw2_write ignored for no state; accepted in every FSM state.
  - Highest-priority search: level (priority_rotate+1) mod 8 is highest, wrapping through 7 -> 0.
  - Reset mid-sequence: FSM returns to IDLE immediately; data_out_enable drops asynchronously.

Optional Feature:
- INTA_SYNC_EN defined: inta_n passes a 2-flop synchronizer before edge detection. All INTA-related latencies grow by 2 cycles; use when inta_n is asynchronous to clock.
- INTA_SYNC_EN undefined: single register only, as described above.

Decomposition:
- Shared package pic_pkg holds:
  - OCW2 command localparams (OCW2_NS_EOI=3'b001, OCW2_SP_EOI=3'b011, OCW2_ROT_NS=3'b101, OCW2_ROT_SP=3'b111, OCW2_SET_PRI=3'b110, OCW2_ROT_AEOI_SET=3'b100, OCW2_ROT_AEOI_CLR=3'b000).
  - Acknowledge FSM state enum.
  - rotate_right/rotate_left functions, shared with the priority resolver.
- One sub-module, isr_highest_finder (combinational):
  - Inputs: isr, priority_rotate.
  - Outputs: one-hot highest set bit and its 3-bit level, plus a valid flag.

Test Plan:
- Reset, interrupt=8'h04, vector_base=5'b00100, two INTA pulses -> int_out=1; isr=8'h04; clear pulse 8'h04; data_out=8'h22 on the second pulse; int_out=0 after it.
- isr=8'h0A, priority_rotate=7, OCW2 001 -> isr=8'h08; repeat -> isr=8'h00; third -> unchanged.
- isr=8'h81, priority_rotate=3'd0 (IR1 highest), OCW2 101 -> isr=8'h01 and priority_rotate=7.
- auto_eoi_config=1, auto_rotate set via OCW2 100, interrupt=8'h20, full INTA -> isr returns to 0 after the second pulse and priority_rotate=5.
- INTA with interrupt=0 -> data_out={vector_base,3'd7}; isr unchanged; no clear pulse.
- OCW2 011 level 2 in the same cycle as first-INTA detection with interrupt=8'h04 and isr=8'h04 -> isr=8'h04 (set wins).
- Assert reset during WAIT2 -> all outputs 0 and state IDLE with no clock edge.
